// File: rtl/ble_cfg_pkg.sv
// Shared types and constants for the BLE configuration AHB-lite master.
// The optional single-retry on slave ERROR is enabled by defining BLE_CFG_RETRY_EN.
package ble_cfg_pkg;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        write;
  } cfg_cmd_t;

  typedef enum logic [1:0] {
    RSP_OKAY     = 2'd0,
    RSP_SLVERR   = 2'd1,
    RSP_TIMEOUT  = 2'd2,
    RSP_MISALIGN = 2'd3
  } rsp_err_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_RESP = 2'd3
  } fsm_state_e;

  localparam logic [1:0]  HTRANS_IDLE   = 2'b00;
  localparam logic [1:0]  HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0]  HSIZE_WORD    = 3'b010;

  localparam logic [31:0] STATUS_REG    = 32'h0100_0000;
  localparam logic [31:0] ADV_FIRST_REG = 32'h0100_0100;
  localparam logic [31:0] ADV_LAST_REG  = 32'h0100_0134;

  function automatic logic is_word_aligned(input logic [31:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/ble_cfg_fifo.sv
// Command FIFO for the BLE configuration master; power-of-two DEPTH, show-ahead head.
module ble_cfg_fifo
  import ble_cfg_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     push,
  input  logic     pop,
  input  cfg_cmd_t din,
  output cfg_cmd_t dout,
  output logic     full,
  output logic     empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0]   COUNT_FULL = DEPTH;
  localparam logic [AW:0]   COUNT_ONE  = 1;
  localparam logic [AW-1:0] PTR_ONE    = 1;

  cfg_cmd_t      mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign full    = (count_q == COUNT_FULL);
  assign empty   = (count_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = do_push ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
    rd_ptr_d = do_pop  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + COUNT_ONE;
      2'b01:   count_d = count_q - COUNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage needs no reset: it is only read while count_q is non-zero.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

endmodule

// File: rtl/ble_cfg_ahb_master.sv
// Single-outstanding AHB-lite master for the BLE register map, with wait-state watchdog.
// Define BLE_CFG_RETRY_EN to reissue a transfer once after a slave ERROR response.
module ble_cfg_ahb_master
  import ble_cfg_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic        hclk,
  input  logic        hresetn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  input  logic        cmd_write,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic [1:0]  rsp_err,
  output logic        hsel,
  output logic        hwrite,
  output logic [1:0]  htrans,
  output logic [2:0]  hsize,
  output logic [31:0] haddr,
  output logic [31:0] hwdata,
  input  logic [31:0] hrdata,
  input  logic        hready,
  input  logic        hresp,
  output logic        busy
);

  localparam logic [7:0] WDOG_LAST = 8'(TIMEOUT - 1);

  cfg_cmd_t   fifo_din, fifo_dout;
  logic       fifo_full, fifo_empty, push, pop;

  fsm_state_e state_q, state_d;
  cfg_cmd_t   cmd_q, cmd_d;
  logic       retried_q, retried_d;
  logic [7:0] wdog_q, wdog_d;
  logic       hsel_q, hsel_d, hwrite_q, hwrite_d;
  logic [1:0] htrans_q, htrans_d;
  logic [2:0] hsize_q, hsize_d;
  logic [31:0] haddr_q, haddr_d, hwdata_q, hwdata_d;
  logic       rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  rsp_err_e   rsp_err_q, rsp_err_d;

  assign fifo_din  = '{addr: cmd_addr, wdata: cmd_wdata, write: cmd_write};
  assign cmd_ready = hresetn & ~fifo_full;
  assign push      = cmd_valid & cmd_ready;
  assign pop       = (state_q == ST_IDLE) & ~fifo_empty;

  ble_cfg_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (hclk),
    .rst_n (hresetn),
    .push  (push),
    .pop   (pop),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    retried_d   = retried_q;
    wdog_d      = 8'd0;
    hsel_d      = hsel_q;
    hwrite_d    = hwrite_q;
    htrans_d    = htrans_q;
    hsize_d     = hsize_q;
    haddr_d     = haddr_q;
    hwdata_d    = hwdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          cmd_d     = fifo_dout;
          retried_d = 1'b0;
          if (!is_word_aligned(fifo_dout.addr)) begin
            state_d     = ST_RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = RSP_MISALIGN;
            rsp_rdata_d = 32'h0;
          end else begin
            state_d  = ST_ADDR;
            hsel_d   = 1'b1;
            htrans_d = HTRANS_NONSEQ;
            haddr_d  = fifo_dout.addr;
            hwrite_d = fifo_dout.write;
            hsize_d  = HSIZE_WORD;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ADDR: begin
        if (hready) begin
          state_d  = ST_DATA;
          hsel_d   = 1'b0;
          htrans_d = HTRANS_IDLE;
          hwdata_d = cmd_q.write ? cmd_q.wdata : 32'h0;
        end else if (wdog_q == WDOG_LAST) begin
          state_d     = ST_RESP;
          hsel_d      = 1'b0;
          htrans_d    = HTRANS_IDLE;
          rsp_valid_d = 1'b1;
          rsp_err_d   = RSP_TIMEOUT;
          rsp_rdata_d = 32'h0;
        end else begin
          wdog_d = wdog_q + 8'd1;
        end
      end
      ST_DATA: begin
        if (hready) begin
          if (hresp) begin
`ifdef BLE_CFG_RETRY_EN
            if (!retried_q) begin
              // Reissue the same command once; no response for the failed attempt.
              state_d   = ST_ADDR;
              retried_d = 1'b1;
              hsel_d    = 1'b1;
              htrans_d  = HTRANS_NONSEQ;
            end else begin
              state_d     = ST_RESP;
              rsp_valid_d = 1'b1;
              rsp_err_d   = RSP_SLVERR;
              rsp_rdata_d = 32'h0;
            end
`else
            state_d     = ST_RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = RSP_SLVERR;
            rsp_rdata_d = 32'h0;
`endif
          end else begin
            state_d     = ST_RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = RSP_OKAY;
            rsp_rdata_d = cmd_q.write ? 32'h0 : hrdata;
          end
        end else if (wdog_q == WDOG_LAST) begin
          state_d     = ST_RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = RSP_TIMEOUT;
          rsp_rdata_d = 32'h0;
        end else begin
          wdog_d = wdog_q + 8'd1;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge hclk) begin
    if (!hresetn) begin
      state_q     <= ST_IDLE;
      cmd_q       <= '0;
      retried_q   <= 1'b0;
      wdog_q      <= 8'd0;
      hsel_q      <= 1'b0;
      hwrite_q    <= 1'b0;
      htrans_q    <= HTRANS_IDLE;
      hsize_q     <= 3'b000;
      haddr_q     <= 32'h0;
      hwdata_q    <= 32'h0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
      rsp_err_q   <= RSP_OKAY;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      retried_q   <= retried_d;
      wdog_q      <= wdog_d;
      hsel_q      <= hsel_d;
      hwrite_q    <= hwrite_d;
      htrans_q    <= htrans_d;
      hsize_q     <= hsize_d;
      haddr_q     <= haddr_d;
      hwdata_q    <= hwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign hsel      = hsel_q;
  assign hwrite    = hwrite_q;
  assign htrans    = htrans_q;
  assign hsize     = hsize_q;
  assign haddr     = haddr_q;
  assign hwdata    = hwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign busy      = ~fifo_empty | (state_q != ST_IDLE);

endmodule

// File: tb/tb_ble_cfg_ahb_master.sv
// Bench for ble_cfg_ahb_master: behavioural AHB slave plus a command-level response model.
module tb_ble_cfg_ahb_master;
  import ble_cfg_pkg::*;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 16;
`ifdef BLE_CFG_RETRY_EN
  localparam bit RETRY = 1'b1;
`else
  localparam bit RETRY = 1'b0;
`endif

  logic        hclk = 1'b0;
  logic        hresetn, cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_err;
  logic        hsel, hwrite;
  logic [1:0]  htrans;
  logic [2:0]  hsize;
  logic [31:0] haddr, hwdata, hrdata;
  logic        hready, hresp, busy;

  ble_cfg_ahb_master #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .hclk(hclk), .hresetn(hresetn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_write(cmd_write),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .hsel(hsel), .hwrite(hwrite), .htrans(htrans), .hsize(hsize),
    .haddr(haddr), .hwdata(hwdata), .hrdata(hrdata), .hready(hready),
    .hresp(hresp), .busy(busy)
  );

  always #5 hclk = ~hclk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        write;
    logic [31:0] rdata;
    logic [31:0] err;
    int          cyc;
  } exp_t;
  typedef struct {
    logic [31:0] rdata;
    logic [31:0] err;
    int          cyc;
  } got_t;

  exp_t exp_q[$];
  got_t got_q[$];
  logic [31:0] slave_mem [logic [31:0]];
  logic [31:0] model_mem [logic [31:0]];

  int checks = 0, errors = 0, cyc = 0, n_addr = 0;
  int addr_wait = 0, data_wait = 0, acnt = 0, dcnt = 0;
  bit err_cfg = 1'b0, iso = 1'b0, pushed = 1'b0, prev_rsp = 1'b0, dphase = 1'b0;
  logic [31:0] daddr;
  logic        dwrite;

  function automatic logic [31:0] init_val(input logic [31:0] a);
    return a ^ 32'h5AC3_0F96;
  endfunction
  function automatic logic [31:0] s_rd(input logic [31:0] a);
    return slave_mem.exists(a) ? slave_mem[a] : init_val(a);
  endfunction
  function automatic logic [31:0] m_rd(input logic [31:0] a);
    return model_mem.exists(a) ? model_mem[a] : init_val(a);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Command-level reference: outcome and latency follow from the slave configuration.
  task automatic model_push();
    exp_t e;
    int lat;
    e.addr = cmd_addr; e.wdata = cmd_wdata; e.write = cmd_write; e.rdata = 32'h0;
    if (cmd_addr[1:0] != 2'b00) begin
      e.err = 32'd3; lat = 2;
    end else if (addr_wait >= TIMEOUT) begin
      e.err = 32'd2; lat = 2 + TIMEOUT;
    end else if (err_cfg) begin
      e.err = 32'd1; lat = RETRY ? (6 + 2 * (addr_wait + data_wait)) : (4 + addr_wait + data_wait);
    end else begin
      e.err = 32'd0; lat = 4 + addr_wait + data_wait;
      if (cmd_write) model_mem[cmd_addr] = cmd_wdata;
      else e.rdata = m_rd(cmd_addr);
    end
    e.cyc = iso ? (cyc + lat) : -1;
    exp_q.push_back(e);
  endtask

  task automatic cur_cmd(output exp_t c, output bit ok);
    ok = (exp_q.size() > got_q.size());
    if (ok) c = exp_q[got_q.size()];
    else chk("bus_without_cmd", 32'(exp_q.size()), 32'(got_q.size() + 1));
  endtask

  task automatic tick();
    exp_t c;
    bit ok, a_acc, d_done;
    #1;
    pushed = hresetn && cmd_valid && cmd_ready;
    if (pushed) model_push();
    a_acc  = hresetn && hsel && (htrans == HTRANS_NONSEQ) && hready;
    d_done = hresetn && dphase && hready;
    if (d_done) begin
      if (dwrite) begin
        cur_cmd(c, ok);
        if (ok) chk("hwdata", hwdata, c.wdata);
        if (!hresp) slave_mem[daddr] = hwdata;
      end
      dphase = 1'b0;
    end
    if (a_acc) begin
      dphase = 1'b1; daddr = haddr; dwrite = hwrite; dcnt = 0; n_addr++;
    end
    @(posedge hclk);
    #1;
    cyc++;
    if (!hresetn) dphase = 1'b0;
    if (rsp_valid) begin
      chk("rsp_single_pulse", 32'(prev_rsp), 32'd0);
      got_q.push_back('{rdata: rsp_rdata, err: 32'(rsp_err), cyc: cyc});
    end
    prev_rsp = rsp_valid;
    if (htrans != HTRANS_IDLE) chk("htrans_legal", 32'(htrans), 32'(HTRANS_NONSEQ));
    hrdata = $urandom();
    hresp  = 1'b0;
    hready = 1'b1;
    if (dphase) begin
      cur_cmd(c, ok);
      if (ok) chk("haddr_data_phase", haddr, c.addr);
      chk("hsel_data_phase", 32'(hsel), 32'd0);
      hready = (dcnt >= data_wait);
      dcnt++;
      if (hready) begin
        hresp = err_cfg;
        if (!dwrite) hrdata = s_rd(daddr);
      end
      acnt = 0;
    end else if (hresetn && hsel && (htrans == HTRANS_NONSEQ)) begin
      cur_cmd(c, ok);
      if (ok) begin
        chk("haddr_addr_phase", haddr, c.addr);
        chk("hwrite_addr_phase", 32'(hwrite), 32'(c.write));
      end
      chk("hsize_addr_phase", 32'(hsize), 32'(HSIZE_WORD));
      hready = (acnt >= addr_wait);
      acnt++;
    end else begin
      acnt = 0;
    end
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] d, input logic w);
    int n = 0;
    cmd_addr = a; cmd_wdata = d; cmd_write = w; cmd_valid = 1'b1;
    do begin
      tick(); n++;
    end while (!pushed && n < 500);
    if (!pushed) chk("push_timeout", 32'(n), 32'd0);
    cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (got_q.size() < exp_q.size() && n < 3000) begin
      tick(); n++;
    end
    repeat (3) tick();
    chk("rsp_count", 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      chk("rsp_err", got_q[i].err, exp_q[i].err);
      chk("rsp_rdata", got_q[i].rdata, exp_q[i].rdata);
      if (exp_q[i].cyc >= 0) chk("rsp_cycle", 32'(got_q[i].cyc), 32'(exp_q[i].cyc));
    end
    exp_q.delete();
    got_q.delete();
  endtask

  initial begin
    int na, aw, dw;
    logic [31:0] a, saved;
    hresetn = 1'b0; cmd_valid = 1'b0; cmd_addr = 32'h0; cmd_wdata = 32'h0; cmd_write = 1'b0;
    hrdata = 32'h0; hready = 1'b1; hresp = 1'b0;

    repeat (3) tick();
    chk("reset_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("reset_htrans", 32'(htrans), 32'(HTRANS_IDLE));
    chk("reset_hsize", 32'(hsize), 32'd0);
    chk("reset_hsel", 32'(hsel), 32'd0);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_rsp_err", 32'(rsp_err), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    hresetn = 1'b1;
    tick();
    chk("release_cmd_ready", 32'(cmd_ready), 32'd1);

    // Zero-wait write with cycle-exact phase checks.
    iso = 1'b1;
    send(STATUS_REG, 32'hDEADBEEF, 1'b1);
    tick();
    chk("t1_haddr", haddr, STATUS_REG);
    chk("t1_htrans_addr", 32'(htrans), 32'(HTRANS_NONSEQ));
    chk("t1_hwrite", 32'(hwrite), 32'd1);
    tick();
    chk("t1_hwdata", hwdata, 32'hDEADBEEF);
    chk("t1_htrans_data", 32'(htrans), 32'(HTRANS_IDLE));
    tick();
    chk("t1_rsp_valid", 32'(rsp_valid), 32'd1);
    drain();

    // Read with three data-phase wait states.
    slave_mem[32'h0100_0104] = 32'h0000_00A5;
    model_mem[32'h0100_0104] = 32'h0000_00A5;
    data_wait = 3;
    send(32'h0100_0104, 32'h0, 1'b0);
    drain();
    data_wait = 0;

    // FIFO fill while the slave stalls address phases.
    iso = 1'b0; addr_wait = 12;
    for (int i = 0; i < DEPTH + 1; i++) send(ADV_FIRST_REG + 32'(4 * i), $urandom(), 1'(i));
    chk("full_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("full_busy", 32'(busy), 32'd1);
    send(ADV_LAST_REG, $urandom(), 1'b0);
    drain();
    addr_wait = 0;

    // Slave ERROR.
    iso = 1'b1; err_cfg = 1'b1; na = n_addr;
    send(ADV_LAST_REG, 32'h1234_5678, 1'b1);
    drain();
    chk("err_addr_phases", 32'(n_addr - na), RETRY ? 32'd2 : 32'd1);
    err_cfg = 1'b0;

    // Watchdog timeout, then a normal command.
    addr_wait = 20; na = n_addr;
    send(ADV_FIRST_REG + 32'h8, 32'hCAFE_0001, 1'b1);
    drain();
    chk("timeout_no_accept", 32'(n_addr), 32'(na));
    addr_wait = 0;
    send(STATUS_REG, 32'h0, 1'b0);
    drain();

    // Misaligned address never reaches the bus.
    na = n_addr;
    send(32'h0100_0102, 32'h0, 1'b0);
    drain();
    chk("misalign_no_bus", 32'(n_addr), 32'(na));

    // Reset during a stalled data phase drops the transfer.
    data_wait = 5; a = ADV_FIRST_REG + 32'hC; saved = m_rd(a);
    send(a, 32'h7777_7777, 1'b1);
    tick(); tick();
    hresetn = 1'b0;
    tick();
    chk("rst_mid_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_mid_cmd_ready", 32'(cmd_ready), 32'd0);
    hresetn = 1'b1;
    model_mem[a] = saved;
    exp_q.delete(); got_q.delete();
    tick();
    chk("rst_rel_busy", 32'(busy), 32'd0);
    chk("rst_rel_cmd_ready", 32'(cmd_ready), 32'd1);
    repeat (10) tick();
    chk("rst_no_rsp", 32'(got_q.size()), 32'd0);
    data_wait = 0;

    // Randomized isolated commands with random waits and errors.
    for (int i = 0; i < 24; i++) begin
      addr_wait = $urandom_range(0, 2);
      data_wait = $urandom_range(0, 2);
      err_cfg   = ($urandom_range(0, 5) == 0);
      a = ADV_FIRST_REG + 32'(4 * $urandom_range(0, 13));
      if ($urandom_range(0, 7) == 0) a = a | 32'($urandom_range(1, 3));
      send(a, $urandom(), 1'($urandom_range(0, 1)));
      drain();
    end
    err_cfg = 1'b0;

    // Randomized back-to-back burst.
    iso = 1'b0; aw = $urandom_range(0, 2); dw = $urandom_range(0, 2);
    addr_wait = aw; data_wait = dw;
    for (int i = 0; i < 12; i++)
      send(ADV_FIRST_REG + 32'(4 * $urandom_range(0, 13)), $urandom(), 1'($urandom_range(0, 1)));
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
